// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin grant, m1 lock ownership,
// out-of-range detection and single-cycle read response routing.
module dmem_arbiter #(
    parameter int AW   = 32,
    parameter int IDXW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [31:0]   m0_rdata,
    output logic [31:0]   m1_rdata,
    output logic          m0_err,
    output logic          m1_err,
    output logic          mem_re,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {ARB, LOCK1} state_t;

    state_t  state_q;
    logic    last_q;            // 1: m1 was granted most recently
    logic    rv0_q, rv1_q;
    logic    err0_q, err1_q;

    logic    m0_oor, m1_oor;
    logic    gnt0, gnt1;
    logic    sel_we, sel_oor;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

    if (AW > IDXW + 2) begin : g_range
        assign m0_oor = |m0_addr[AW-1:IDXW+2];
        assign m1_oor = |m1_addr[AW-1:IDXW+2];
    end else begin : g_norange
        assign m0_oor = 1'b0;
        assign m1_oor = 1'b0;
    end

    // A held lock overrides the pointer; once it drops, m1 competes normally.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (state_q == LOCK1 && m1_lock) begin
                gnt1 = m1_req;
            end else if (m0_req && m1_req) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_oor   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = m0_we;
            sel_oor   = m0_oor;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (gnt1) begin
            sel_we    = m1_we;
            sel_oor   = m1_oor;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign mem_re    = (gnt0 | gnt1) & ~sel_we & ~sel_oor;
    assign mem_we    = (gnt0 | gnt1) & sel_we & ~sel_oor;
    assign mem_addr  = 32'(sel_addr) & ~32'h3;
    assign mem_wdata = sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB:     if (gnt1 && m1_lock) state_q <= LOCK1;
                LOCK1:   if (!m1_lock) state_q <= ARB;
                default: state_q <= ARB;
            endcase
            if (gnt0 | gnt1) last_q <= gnt1;
            rv0_q  <= gnt0 & ~m0_we & ~m0_oor;
            rv1_q  <= gnt1 & ~m1_we & ~m1_oor;
            err0_q <= gnt0 & m0_oor;
            err1_q <= gnt1 & m1_oor;
        end
    end

    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign m0_rdata  = rv0_q ? mem_rdata : '0;
    assign m1_rdata  = rv1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expected grants and
// responses; a negedge monitor pops and compares against the DUT.
module tb_dmem_arbiter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ram [1024];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .IDXW(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_err(m0_err), .m1_err(m1_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // dmem with one-cycle registered read
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr[11:2]];
    end

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic g0, g1, re, we;
        logic [31:0] addr, wdata;
        bit chk_a, chk_w;
    } gexp_t;

    typedef struct {
        bit port;
        bit err;
        logic [31:0] data;
        int unsigned cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int nvec = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_cnt, act, exp);
        end
    endfunction

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1, input logic lk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
    endtask

    task automatic idle_inputs();
        drive(F, F, 32'h0, 32'h0, F, F, 32'h0, 32'h0, F);
    endtask

    task automatic cyc(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1, input logic lk,
                       input logic eg0, eg1, ere, ewe);
        gexp_t g;
        @(posedge clk);
        #1;
        drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);
        g.g0 = eg0; g.g1 = eg1; g.re = ere; g.we = ewe;
        g.addr  = eg0 ? a0 : a1;
        g.wdata = eg0 ? d0 : d1;
        g.chk_a = eg0 | eg1;
        g.chk_w = ewe;
        gq.push_back(g);
    endtask

    task automatic idle();
        cyc(F, F, 32'h0, 32'h0, F, F, 32'h0, 32'h0, F, F, F, F, F);
    endtask

    task automatic expect_rsp(input bit port, input bit err, input logic [31:0] data);
        rexp_t r;
        r.port = port; r.err = err; r.data = data; r.cyc = cyc_cnt + 1;
        rq.push_back(r);
    endtask

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        logic [3:0] flags, eflags;
        if (mon_en) begin
            if (gq.size() > 0) begin
                g = gq.pop_front();
                chk("grant{g0,g1,re,we}", {m0_gnt, m1_gnt, mem_re, mem_we}, {g.g0, g.g1, g.re, g.we});
                if (g.chk_a) chk("mem_addr", mem_addr, g.addr);
                if (g.chk_w) chk("mem_wdata", mem_wdata, g.wdata);
            end
            flags = {m0_rvalid, m0_err, m1_rvalid, m1_err};
            if (flags != 4'b0) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", flags, 64'h0);
                end else begin
                    r = rq.pop_front();
                    eflags = r.port ? {2'b00, ~r.err, r.err} : {~r.err, r.err, 2'b00};
                    chk("rsp_cycle", cyc_cnt, r.cyc);
                    chk("rsp_flags", flags, eflags);
                    chk("rsp_data", r.port ? m1_rdata : m0_rdata, r.data);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc_cnt) begin
                r = rq.pop_front();
                eflags = r.port ? {2'b00, ~r.err, r.err} : {~r.err, r.err, 2'b00};
                chk("missing_rsp", flags, eflags);
            end
            if (!m0_rvalid) chk("m0_rdata_idle", m0_rdata, 64'h0);
            if (!m1_rvalid) chk("m1_rdata_idle", m1_rdata, 64'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        ram[0] <= 32'h1111_1111;
        ram[1] <= 32'h2222_2222;
        ram[2] <= 32'h3333_3333;
        ram[4] <= 32'hA5A5_A5A5;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // requests while reset held: nothing granted
        cyc(T, F, 32'h10, 32'h0, T, T, 32'h4, 32'h5, F, F, F, F, F);
        @(negedge clk); #1; rst = 1'b0; idle_inputs();

        // single read, zero-wait grant, data next cycle
        cyc(T, F, 32'h10, 32'h0, F, F, 32'h0, 32'h0, F, T, F, T, F);
        expect_rsp(0, 0, 32'hA5A5_A5A5);
        idle();

        // fresh reset, then both requesting: m0 first, then alternate
        @(negedge clk); #1; rst = 1'b1; idle_inputs();
        @(negedge clk); #1; rst = 1'b0;
        cyc(T, T, 32'h20, 32'hDEAD_0001, T, F, 32'h4, 32'h0, F, T, F, F, T);
        cyc(T, T, 32'h20, 32'hDEAD_0001, T, F, 32'h4, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'h2222_2222);
        cyc(T, T, 32'h20, 32'hDEAD_0001, T, F, 32'h4, 32'h0, F, T, F, F, T);
        cyc(T, T, 32'h20, 32'hDEAD_0001, T, F, 32'h4, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'h2222_2222);
        cyc(F, F, 32'h0, 32'h0, T, F, 32'h20, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'hDEAD_0001);

        // m1 locked burst keeps m0 waiting
        cyc(F, F, 32'h0, 32'h0, T, T, 32'h100, 32'hB0, T, F, T, F, T);
        cyc(T, F, 32'h8, 32'h0, T, T, 32'h104, 32'hB1, T, F, T, F, T);
        cyc(T, F, 32'h8, 32'h0, T, T, 32'h108, 32'hB2, T, F, T, F, T);
        cyc(T, F, 32'h8, 32'h0, T, T, 32'h10C, 32'hB3, T, F, T, F, T);
        cyc(T, F, 32'h8, 32'h0, F, F, 32'h0, 32'h0, F, T, F, T, F);
        expect_rsp(0, 0, 32'h3333_3333);
        cyc(T, F, 32'h10C, 32'h0, F, F, 32'h0, 32'h0, F, T, F, T, F);
        expect_rsp(0, 0, 32'h0000_00B3);

        // lock dropped in LOCK1 while both request: round-robin gives m0
        cyc(F, F, 32'h0, 32'h0, T, T, 32'h110, 32'hC0, T, F, T, F, T);
        cyc(T, F, 32'h0, 32'h0, T, T, 32'h114, 32'hC1, F, T, F, T, F);
        expect_rsp(0, 0, 32'h1111_1111);
        cyc(F, F, 32'h0, 32'h0, T, T, 32'h114, 32'hC1, F, F, T, F, T);

        // out-of-range read and write: granted, no strobe, err next cycle
        cyc(T, F, 32'h1000, 32'h0, F, F, 32'h0, 32'h0, F, T, F, F, F);
        expect_rsp(0, 1, 32'h0);
        cyc(F, F, 32'h0, 32'h0, T, T, 32'h2000, 32'h77, F, F, T, F, F);
        expect_rsp(1, 1, 32'h0);

        // back-to-back pipelined reads
        cyc(T, F, 32'h0, 32'h0, F, F, 32'h0, 32'h0, F, T, F, T, F);
        expect_rsp(0, 0, 32'h1111_1111);
        cyc(F, F, 32'h0, 32'h0, T, F, 32'h4, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'h2222_2222);
        idle();

        // m1_lock ignored when m1 loses arbitration
        cyc(T, F, 32'h8, 32'h0, T, F, 32'h4, 32'h0, T, T, F, T, F);
        expect_rsp(0, 0, 32'h3333_3333);
        cyc(T, F, 32'h10, 32'h0, F, F, 32'h0, 32'h0, T, T, F, T, F);
        expect_rsp(0, 0, 32'hA5A5_A5A5);
        cyc(F, F, 32'h0, 32'h0, T, F, 32'h4, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'h2222_2222);

        // reset pulse between grant and response drops the response
        cyc(T, F, 32'h0, 32'h0, F, F, 32'h0, 32'h0, F, T, F, T, F);
        #6; rst = 1'b1; idle_inputs();
        #1; rst = 1'b0;
        idle();
        cyc(T, F, 32'h8, 32'h0, T, F, 32'h0, 32'h0, F, T, F, T, F);
        expect_rsp(0, 0, 32'h3333_3333);
        cyc(F, F, 32'h0, 32'h0, T, F, 32'h0, 32'h0, F, F, T, T, F);
        expect_rsp(1, 0, 32'h1111_1111);

        repeat (3) idle();
        @(posedge clk);
        #1;
        chk("rsp_queue_drained", rq.size(), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width of requester addresses.
REQ-002 SHALL have parameter IDXW, default 10, word-index width driven to dmem (1024 words).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req/m1_req  input  1  access request, held until granted.
REQ-006 SHALL have ports m0_we/m1_we  input  1  1=write, 0=read, valid with req.
REQ-007 SHALL have ports m0_addr/m1_addr  input  AW  byte address; bits [1:0] ignored.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-009 SHALL have port m1_lock  input  1  m1 keeps ownership for back-to-back accesses.
REQ-010 SHALL have ports m0_gnt/m1_gnt  output  1  access accepted this cycle.
REQ-011 SHALL have ports m0_rvalid/m1_rvalid  output  1  read data valid.
REQ-012 SHALL have ports m0_rdata/m1_rdata  output  32  read data.
REQ-013 SHALL have ports m0_err/m1_err  output  1  out-of-range access flagged, same cycle as rvalid slot.
REQ-014 SHALL have ports mem_re, mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_rdata  input  32 (dmem with 1-cycle registered read).

Function
REQ-015 SHALL grant at most one requester per cycle; gnt combinational from req, state and pointer.
REQ-016 SHALL grant sole requester immediately (zero wait) when not in LOCK held by the other.
REQ-017 SHALL on simultaneous m0_req and m1_req in state ARB grant the requester not granted last (round-robin pointer last_gnt).
REQ-018 SHALL update last_gnt on every grant cycle.
REQ-019 SHALL drive mem_re=gnt&~we, mem_we=gnt&we, mem_addr/mem_wdata from granted requester; all mem strobes 0 when no grant.
REQ-020 SHALL treat address with any of bits [AW-1:IDXW+2] set as out of range: grant issued, mem_re/mem_we suppressed, errN pulsed 1 cycle later.
REQ-021 SHALL assert mN_rvalid exactly one cycle after an in-range read grant, mN_rdata = mem_rdata in that cycle; rvalid is one-cycle pulse.
REQ-022 SHALL drive mN_rdata to 0 when mN_rvalid is 0.
REQ-023 SHALL produce no rvalid for writes; write completes at the grant edge.
REQ-024 SHALL support one grant per cycle throughput (pipelined reads back-to-back).
REQ-025 SHALL implement FSM states ARB and LOCK1.
REQ-026 SHALL move ARB->LOCK1 when m1 granted with m1_lock=1.
REQ-027 SHALL in LOCK1 grant only m1 (m0 waits regardless of pointer); stay while m1_lock=1.
REQ-028 SHALL move LOCK1->ARB when m1_lock=0, in the same cycle m1_lock is sampled low; m1 access that cycle still grants if m1_req and no m0_req priority applies by round-robin.
REQ-029 SHALL ignore m1_lock when m1 is not granted in ARB.

Reset
REQ-030 SHALL on rst: state=ARB, last_gnt=m1 (m0 wins first conflict), all gnt/rvalid/err/mem strobes 0, rdata 0.
REQ-031 SHALL drop pending rvalid/err when rst asserts mid-read; no response after rst deassertion.
REQ-032 SHALL force gnt and mem strobes to 0 while rst asserted regardless of req.

Verification
REQ-033 Reset then m0 read addr 0x10 (ram[4]=0xA5A5A5A5) -> m0_gnt same cycle, mem_addr=0x10, mem_re=1; next cycle m0_rvalid=1, m0_rdata=0xA5A5A5A5.
REQ-034 Both req held 4 cycles after reset -> grants m0,m1,m0,m1; mem_we only on write-requester cycles.
REQ-035 m1 writes 0x100..0x10C with m1_lock=1 while m0_req=1 -> 4 m1 grants consecutive, m0_gnt=0 until cycle after m1_lock falls.
REQ-036 m0 read addr 0x1000 -> m0_gnt=1, mem_re=0, next cycle m0_err=1, m0_rvalid=0.
REQ-037 m0 read granted, rst pulsed before next edge -> m0_rvalid stays 0; post-reset state ARB, last_gnt=m1.
REQ-038 Back-to-back reads m0 0x0 then m1 0x4 -> m0_rvalid cycle n+1, m1_rvalid cycle n+2, data ram[0], ram[1].
